lcd_row_driver: RTL and testbench
=================================

Name: lcd_row_driver

Overview:
- Downstream consumer of the 128-bit display rows (row 1 / row 2, 16 ASCII chars each) produced by the player and host display FSMs.
- Drives one HD44780-compatible 16x2 character LCD over the 8-bit parallel bus.
- Runs the power-up init sequence once, then continuously refreshes both rows.
- One instance per LCD (player, host); rows are snapshotted per frame to avoid tearing.

Parameters:
- POWERUP_CYC, 150000: cycles held idle after reset before the first command (≥15 ms at 10 MHz).
- BYTE_CYC, 500: total cycles per ordinary byte write, command or data (≥40 us plus margin).
- EN_HIGH_CYC, 10: cycles lcd_en is high within a byte write; must be ≤ BYTE_CYC-4.
- CLEAR_CYC, 20000: total cycles for the clear-display command (≥1.64 ms).

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- row_1  in  128  top row; char 0 (leftmost) = [127:120], char 15 = [7:0]
- row_2  in  128  bottom row; same packing
- lcd_en  out  1  LCD enable strobe
- lcd_rw  out  1  read/write select; tied 0 (write only)
- lcd_rs  out  1  0 = command, 1 = data
- lcd_data  out  8  LCD data bus
- init_done  out  1  high once the init sequence completes; stays high until reset
- frame_done  out  1  one-cycle pulse after the last char of row 2 is written

Behaviour:
- Reset (async, nRst=0): lcd_en=0, lcd_rw=0, lcd_rs=0, lcd_data=8'h00, init_done=0, frame_done=0, state=POWERUP, all counters 0, snapshots 0.
  - Reset mid-write aborts immediately: en drops asynchronously, and the sequence restarts from POWERUP.
- Byte write timing, cycle k counted from write start (k=0):
  - rs and data valid from k=0 and held through the last cycle.
  - en=1 for k in [2, 2+EN_HIGH_CYC-1]; en=0 otherwise.
  - Write lasts BYTE_CYC cycles (CLEAR_CYC for 8'h01). The next write starts on the following cycle.
- States:
  - POWERUP: count POWERUP_CYC cycles with the bus idle, then go to INIT.
  - INIT: commands in order 8'h38, 8'h0C, 8'h06, 8'h01 (rs=0). After the clear completes, set init_done=1 and go to ADDR1.
  - ADDR1: on the entry cycle, latch row_1 and row_2 into snapshot registers, then write command 8'h80.
  - ROW1: 16 data writes (rs=1), char index 0..15, taken from snapshot 1 MSB byte first.
  - ADDR2: command 8'hC0.
  - ROW2: 16 data writes from snapshot 2.
  - After the 16th ROW2 write ends, pulse frame_done on the next cycle and enter ADDR1 on that same cycle. Refresh is continuous with no gap.
- Row inputs changing mid-frame have no effect until the next ADDR1 snapshot.
- Char index wraps 15 to 0 only via the state change, never by counter overflow.
- Data bytes are passed verbatim; no ASCII filtering.
- Frame length after init = 34*BYTE_CYC + 1 cycles.

Decomposition:
- Package lcd_pkg holds:
  - Command constants: CMD_FUNC_SET=8'h38, CMD_DISP_ON=8'h0C, CMD_ENTRY=8'h06, CMD_CLEAR=8'h01, CMD_LINE1=8'h80, CMD_LINE2=8'hC0.
  - State enum: POWERUP, INIT, ADDR1, ROW1, ADDR2, ROW2.
- Sub-module lcd_byte_writer handles the timing of a single byte:
  - Inputs: start, rs, byte, long (selects CLEAR_CYC).
  - Outputs: lcd_en, lcd_rs, lcd_data, done (one-cycle pulse in the last cycle).
  - start is ignored while busy.
- The top FSM sequences lcd_byte_writer.

Test Plan (sim params POWERUP_CYC=20, BYTE_CYC=8, EN_HIGH_CYC=3, CLEAR_CYC=30):
- Release reset, rows 0 -> bus idle (en=0, data=00) for 20 cycles, then writes 38, 0C, 06, 01 with rs=0. Each en pulse is exactly 3 cycles starting at offset 2. init_done rises after 20+3*8+30 cycles.
- row_1="HANGMAN GAME    ", row_2="GUESS: _ _ _ _ _" -> after init: 80, then 16 rs=1 bytes 48 41 4E..., then C0 and row_2 bytes in order. frame_done pulses once, 34*8 cycles after ADDR1 starts.
- Change row_1 to all 8'h41 during ROW1 char 5 -> the rest of that frame still shows the old chars. The next frame shows sixteen 41s.
- Hold rows constant across 3 frames -> frame_done period is exactly 273 cycles, and the byte sequence is identical each frame.
- Assert nRst during ROW2 char 7 with en high -> en=0 immediately, outputs at reset values. After release, the full POWERUP/INIT sequence repeats and init_done=0 until it completes.
- Check lcd_rw=0 throughout all scenarios, and data/rs stable whenever en=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the HD44780 16x2 row driver.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    POWERUP = 3'd0,
    INIT    = 3'd1,
    ADDR1   = 3'd2,
    ROW1    = 3'd3,
    ADDR2   = 3'd4,
    ROW2    = 3'd5
  } lcd_state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    logic [7:0] cmd;
    case (step)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_ENTRY;
      default: cmd = CMD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Char 0 is the leftmost character and sits in the top byte of the row.
  function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] idx);
    logic [3:0] pos;
    pos = 4'd15 - idx;
    return row[{pos, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd_row_driver_if.sv
// Parallel 8-bit HD44780 write bus between the row driver and the panel.
// Strobe bus, no valid/ready: rs/data are stable for the whole write and the panel latches on the falling edge of lcd_en.
interface lcd_row_driver_if;
  logic       lcd_en;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [7:0] lcd_data;

  modport master (output lcd_en, lcd_rw, lcd_rs, lcd_data);
  modport slave  (input  lcd_en, lcd_rw, lcd_rs, lcd_data);
endinterface

// File: rtl/lcd_byte_writer.sv
// Timing engine for one LCD byte write: holds rs/data for the whole write and
// strobes lcd_en in a fixed window; done marks the last cycle of the write.
module lcd_byte_writer #(
  parameter int BYTE_CYC    = 500,
  parameter int EN_HIGH_CYC = 10,
  parameter int CLEAR_CYC   = 20000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_cyc,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done,
  output logic       busy
);

  localparam int MAX_CYC = (CLEAR_CYC > BYTE_CYC) ? CLEAR_CYC : BYTE_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] BYTE_LAST  = CW'(BYTE_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYC - 1);
  localparam logic [CW-1:0] EN_FIRST   = CW'(2);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_HIGH_CYC + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          long_q;
  logic          accept;

  assign cnt_nxt = cnt + CW'(1);
  assign done    = busy && (cnt == (long_q ? CLEAR_LAST : BYTE_LAST));
  // Accepting in the done cycle lets back-to-back writes run with no idle gap.
  assign accept  = start && (!busy || done);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      busy     <= 1'b0;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (accept) begin
      busy     <= 1'b1;
      cnt      <= '0;
      long_q   <= long_cyc;
      lcd_en   <= 1'b0;
      lcd_rs   <= rs;
      lcd_data <= data;
    end else if (busy) begin
      if (done) begin
        busy   <= 1'b0;
        cnt    <= '0;
        lcd_en <= 1'b0;
      end else begin
        cnt    <= cnt_nxt;
        lcd_en <= (cnt_nxt >= EN_FIRST) && (cnt_nxt <= EN_LAST);
      end
    end
  end

endmodule

// File: rtl/lcd_row_driver.sv
// Sequences the LCD power-up/init commands once, then refreshes both rows
// forever from per-frame snapshots so a frame never mixes old and new text.
module lcd_row_driver
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC = 150000,
  parameter int BYTE_CYC    = 500,
  parameter int EN_HIGH_CYC = 10,
  parameter int CLEAR_CYC   = 20000
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic [127:0]        row_1,
  input  logic [127:0]        row_2,
  lcd_row_driver_if.master    lcd,
  output logic                init_done,
  output logic                frame_done,
  output lcd_state_t          state
);

  localparam int PW = $clog2(POWERUP_CYC + 1);
  localparam logic [PW-1:0] PU_LAST = PW'(POWERUP_CYC - 1);

  lcd_state_t     state_nxt;
  logic [3:0]     idx;
  logic [3:0]     idx_nxt;
  logic [3:0]     idx_p1;
  logic [PW-1:0]  pu_cnt;
  logic [PW-1:0]  pu_nxt;
  logic [127:0]   snap_1;
  logic [127:0]   snap_2;

  logic           wr_start;
  logic           wr_rs;
  logic [7:0]     wr_data;
  logic           wr_long;
  logic           wr_done;
  logic           wr_busy;
  logic           wr_en;
  logic           wr_rs_q;
  logic [7:0]     wr_data_q;
  logic           snap_load;
  logic           init_set;
  logic           frame_pulse;

  lcd_byte_writer #(
    .BYTE_CYC    (BYTE_CYC),
    .EN_HIGH_CYC (EN_HIGH_CYC),
    .CLEAR_CYC   (CLEAR_CYC)
  ) u_writer (
    .clk      (clk),
    .nRst     (nRst),
    .start    (wr_start),
    .rs       (wr_rs),
    .data     (wr_data),
    .long_cyc (wr_long),
    .lcd_en   (wr_en),
    .lcd_rs   (wr_rs_q),
    .lcd_data (wr_data_q),
    .done     (wr_done),
    .busy     (wr_busy)
  );

  assign lcd.lcd_en   = wr_en;
  assign lcd.lcd_rw   = 1'b0;
  assign lcd.lcd_rs   = wr_rs_q;
  assign lcd.lcd_data = wr_data_q;

  assign idx_p1 = idx + 4'd1;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= POWERUP;
      idx        <= 4'd0;
      pu_cnt     <= '0;
      snap_1     <= '0;
      snap_2     <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      pu_cnt     <= pu_nxt;
      frame_done <= frame_pulse;
      if (init_set) init_done <= 1'b1;
      if (snap_load) begin
        snap_1 <= row_1;
        snap_2 <= row_2;
      end
    end
  end

  // Every follow-on write is launched in the done cycle of the previous one.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pu_nxt      = pu_cnt;
    wr_start    = 1'b0;
    wr_rs       = 1'b0;
    wr_data     = 8'h00;
    wr_long     = 1'b0;
    snap_load   = 1'b0;
    init_set    = 1'b0;
    frame_pulse = 1'b0;
    case (state)
      POWERUP: begin
        if (pu_cnt == PU_LAST) begin
          wr_start  = 1'b1;
          wr_data   = init_cmd(2'd0);
          idx_nxt   = 4'd0;
          state_nxt = INIT;
        end else begin
          pu_nxt = pu_cnt + PW'(1);
        end
      end
      INIT: begin
        if (wr_done) begin
          if (idx == 4'd3) begin
            init_set  = 1'b1;
            idx_nxt   = 4'd0;
            state_nxt = ADDR1;
          end else begin
            idx_nxt  = idx_p1;
            wr_start = 1'b1;
            wr_data  = init_cmd(idx_p1[1:0]);
            wr_long  = (idx_p1 == 4'd3);
          end
        end
      end
      ADDR1: begin
        // The writer is idle only on the entry cycle; that is the snapshot point.
        if (!wr_busy) begin
          snap_load = 1'b1;
          wr_start  = 1'b1;
          wr_data   = CMD_LINE1;
        end else if (wr_done) begin
          idx_nxt   = 4'd0;
          wr_start  = 1'b1;
          wr_rs     = 1'b1;
          wr_data   = row_char(snap_1, 4'd0);
          state_nxt = ROW1;
        end
      end
      ROW1: begin
        if (wr_done) begin
          if (idx == 4'd15) begin
            wr_start  = 1'b1;
            wr_data   = CMD_LINE2;
            state_nxt = ADDR2;
          end else begin
            idx_nxt  = idx_p1;
            wr_start = 1'b1;
            wr_rs    = 1'b1;
            wr_data  = row_char(snap_1, idx_p1);
          end
        end
      end
      ADDR2: begin
        if (wr_done) begin
          idx_nxt   = 4'd0;
          wr_start  = 1'b1;
          wr_rs     = 1'b1;
          wr_data   = row_char(snap_2, 4'd0);
          state_nxt = ROW2;
        end
      end
      ROW2: begin
        if (wr_done) begin
          if (idx == 4'd15) begin
            idx_nxt     = 4'd0;
            frame_pulse = 1'b1;
            state_nxt   = ADDR1;
          end else begin
            idx_nxt  = idx_p1;
            wr_start = 1'b1;
            wr_rs    = 1'b1;
            wr_data  = row_char(snap_2, idx_p1);
          end
        end
      end
      default: state_nxt = POWERUP;
    endcase
  end

endmodule

// File: tb/tb_lcd_row_driver.sv
// Directed bench for lcd_row_driver with shortened timing parameters.
module tb_lcd_row_driver;
  import lcd_pkg::*;

  localparam int POWERUP_CYC = 20;
  localparam int BYTE_CYC    = 8;
  localparam int EN_HIGH_CYC = 3;
  localparam int CLEAR_CYC   = 30;

  // Hand-computed: init_done at 20+3*8+30, frame period 34*8+1, first frame_done 74+273.
  localparam int INIT_DONE_AT   = 74;
  localparam int FRAME_PERIOD   = 273;
  localparam int FIRST_FRAME_AT = 347;

  logic         clk = 1'b0;
  logic         nRst;
  logic [127:0] row_1;
  logic [127:0] row_2;
  logic         init_done;
  logic         frame_done;
  lcd_state_t   state;

  lcd_row_driver_if bus();

  lcd_row_driver #(
    .POWERUP_CYC (POWERUP_CYC),
    .BYTE_CYC    (BYTE_CYC),
    .EN_HIGH_CYC (EN_HIGH_CYC),
    .CLEAR_CYC   (CLEAR_CYC)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .row_1      (row_1),
    .row_2      (row_2),
    .lcd        (bus),
    .init_done  (init_done),
    .frame_done (frame_done),
    .state      (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge nRst) begin
    if (!nRst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] cap_q[$];
  int         rise_q[$];
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bus monitor: logs {rs,data} at each en rise, checks en width, bus stability and rw.
  bit         prev_en = 1'b0;
  int         en_w    = 0;
  logic [8:0] held    = '0;

  always @(negedge clk) begin
    if (!nRst) begin
      prev_en = 1'b0;
      en_w    = 0;
    end else begin
      check("rw_low", 32'(bus.lcd_rw), 32'd0);
      if (bus.lcd_en) begin
        if (!prev_en) begin
          held = {bus.lcd_rs, bus.lcd_data};
          cap_q.push_back(held);
          rise_q.push_back(cyc);
          en_w = 0;
        end else begin
          check("bus_stable", 32'({bus.lcd_rs, bus.lcd_data}), 32'(held));
        end
        en_w++;
      end else if (prev_en) begin
        check("en_width", 32'(en_w), 32'(EN_HIGH_CYC));
      end
      prev_en = bus.lcd_en;
    end
  end

  // ---------------- driver / checking tasks ----------------
  task automatic run_init(input bit set_rows);
    logic [8:0] init_exp[4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
    int n;
    for (int c = 0; c < POWERUP_CYC; c++) begin
      check("pu_en", 32'(bus.lcd_en), 32'd0);
      check("pu_data", 32'(bus.lcd_data), 32'd0);
      if (c == 0) check("pu_init_done", 32'(init_done), 32'd0);
      if (set_rows && c == 10) begin
        row_1 = "HANGMAN GAME    ";
        row_2 = "GUESS: _ _ _ _ _";
      end
      @(negedge clk);
    end
    n = 0;
    while (!init_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("init_done_cyc", 32'(cyc), 32'(INIT_DONE_AT));
    check("init_state", 32'(state), 32'(ADDR1));
    check("init_count", 32'(cap_q.size()), 32'd4);
    if (cap_q.size() == 4 && rise_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("init_byte%0d", i), 32'(cap_q[i]), 32'(init_exp[i]));
        check($sformatf("init_en_rise%0d", i), 32'(rise_q[i]), 32'(22 + 8 * i));
      end
    end
    cap_q.delete();
    rise_q.delete();
  endtask

  task automatic wait_frame(output int at);
    at = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (frame_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("frame_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_frame(input string s1, input string s2);
    exp_q.delete();
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, s1.getc(i)});
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, s2.getc(i)});
    check("frame_len", 32'(cap_q.size()), 32'd34);
    if (cap_q.size() == 34) begin
      for (int i = 0; i < 34; i++)
        check($sformatf("frame_byte%0d", i), 32'(cap_q.pop_front()), 32'(exp_q.pop_front()));
    end
    cap_q.delete();
    rise_q.delete();
  endtask

  // ---------------- main sequence ----------------
  int fd;
  int prev_fd;

  initial begin
    nRst  = 1'b0;
    row_1 = '0;
    row_2 = '0;
    repeat (3) @(negedge clk);
    check("rst_en", 32'(bus.lcd_en), 32'd0);
    check("rst_rs", 32'(bus.lcd_rs), 32'd0);
    check("rst_data", 32'(bus.lcd_data), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_state", 32'(state), 32'(POWERUP));

    nRst = 1'b1;
    run_init(1'b1);

    wait_frame(fd);
    check("first_frame_cyc", 32'(fd), 32'(FIRST_FRAME_AT));
    check("frame_state", 32'(state), 32'(ADDR1));
    check_frame("HANGMAN GAME    ", "GUESS: _ _ _ _ _");
    prev_fd = fd;
    @(negedge clk);
    check("frame_done_pulse", 32'(frame_done), 32'd0);

    // ROW1 char 5 of the next frame is written over cycles prev+49..prev+56.
    while (cyc < prev_fd + 51) @(negedge clk);
    check("change_en", 32'(bus.lcd_en), 32'd1);
    check("change_state", 32'(state), 32'(ROW1));
    row_1 = "AAAAAAAAAAAAAAAA";
    wait_frame(fd);
    check("period_f2", 32'(fd - prev_fd), 32'(FRAME_PERIOD));
    check_frame("HANGMAN GAME    ", "GUESS: _ _ _ _ _");
    prev_fd = fd;

    for (int k = 0; k < 3; k++) begin
      wait_frame(fd);
      check($sformatf("period_steady%0d", k), 32'(fd - prev_fd), 32'(FRAME_PERIOD));
      check_frame("AAAAAAAAAAAAAAAA", "GUESS: _ _ _ _ _");
      prev_fd = fd;
    end

    // ROW2 char 7 en window is prev+203..prev+205.
    while (cyc < prev_fd + 204) @(negedge clk);
    check("pre_reset_en", 32'(bus.lcd_en), 32'd1);
    check("pre_reset_state", 32'(state), 32'(ROW2));
    check("pre_reset_data", 32'(bus.lcd_data), 32'h5F);
    #2 nRst = 1'b0;
    #1;
    check("abort_en", 32'(bus.lcd_en), 32'd0);
    check("abort_rs", 32'(bus.lcd_rs), 32'd0);
    check("abort_data", 32'(bus.lcd_data), 32'd0);
    check("abort_init_done", 32'(init_done), 32'd0);
    check("abort_state", 32'(state), 32'(POWERUP));
    repeat (2) @(negedge clk);
    cap_q.delete();
    rise_q.delete();
    nRst = 1'b1;
    run_init(1'b0);
    wait_frame(fd);
    check("restart_frame_cyc", 32'(fd), 32'(FIRST_FRAME_AT));
    check_frame("AAAAAAAAAAAAAAAA", "GUESS: _ _ _ _ _");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
